// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_IWAIT = 3'd1,
        ST_REDIR = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    // Instruction word loaded into IF/ID when it is flushed.
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    localparam int FLUSH_MIN = 1;
    localparam int FLUSH_MAX = 7;

    // FLUSH_CYCLES must fit the 3-bit flush counter; out-of-range values are
    // clamped so the counter can never wrap.
    function automatic int flush_cycles_checked(input int n);
        if (n < FLUSH_MIN) return FLUSH_MIN;
        if (n > FLUSH_MAX) return FLUSH_MAX;
        return n;
    endfunction

endpackage

// File: rtl/register_16bits.sv
// 16-bit register with write enable and asynchronous active-high clear.
module register_16bits (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Capture d when enabled; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 16'h0000;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges fetch waits, data-memory waits,
// load-use hazards, redirects and HALT into one per-cycle enable set.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instructionMemoryStall,
    input  logic             instructionMemoryDone,
    input  logic             dataMemoryStall,
    input  logic             loadUseHazard,
    input  logic             branchTaken,
    input  logic [15:0]      branchTarget,
    input  logic             haltRetire,
    output logic             pcEn,
    output logic             ifIdEn,
    output logic             ifIdFlush,
    output logic             idExBubble,
    output logic             backEn,
    output logic             redirectValid,
    output logic [15:0]      redirectPC,
    output logic             halted,
    output logic [CNT_W-1:0] stallCount
);

    localparam int          FLUSH_EFF  = flush_cycles_checked(FLUSH_CYCLES);
    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_EFF - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  flush_cnt;
    logic [2:0]  flush_cnt_next;
    logic        saved_we;
    logic [15:0] saved_target;
    logic        take_redirect;

    // Redirect target captured while a fetch is still outstanding.
    register_16bits u_saved_target (
        .clk (clk),
        .rst (rst),
        .en  (saved_we),
        .d   (branchTarget),
        .q   (saved_target)
    );

    // State and flush counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Count cycles in which the PC is held while not halted; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= '0;
        end else if (!pcEn && state != ST_HALT && stallCount != {CNT_W{1'b1}}) begin
            stallCount <= stallCount + 1'b1;
        end
    end

    // Next-state and same-cycle enable decode.
    always_comb begin
        pcEn           = 1'b1;
        ifIdEn         = 1'b1;
        backEn         = 1'b1;
        ifIdFlush      = 1'b0;
        idExBubble     = 1'b0;
        redirectValid  = 1'b0;
        redirectPC     = 16'h0000;
        halted         = 1'b0;
        state_next     = state;
        flush_cnt_next = flush_cnt;
        saved_we       = 1'b0;
        take_redirect  = 1'b0;

        if (state == ST_HALT) begin
            pcEn   = 1'b0;
            ifIdEn = 1'b0;
            backEn = 1'b0;
            halted = 1'b1;
        end else if (dataMemoryStall) begin
            // Whole pipeline frozen; state and flush counter hold.
            pcEn   = 1'b0;
            ifIdEn = 1'b0;
            backEn = 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (branchTaken) begin
                        redirectValid = 1'b1;
                        redirectPC    = branchTarget;
                        ifIdFlush     = 1'b1;
                        idExBubble    = 1'b1;
                        take_redirect = 1'b1;
                    end else if (loadUseHazard) begin
                        pcEn       = 1'b0;
                        ifIdEn     = 1'b0;
                        idExBubble = 1'b1;
                    end else if (instructionMemoryStall) begin
                        pcEn       = 1'b0;
                        ifIdFlush  = 1'b1;
                        state_next = ST_IWAIT;
                    end
                end
                ST_IWAIT: begin
                    if (branchTaken) begin
                        // Fetch in flight: park the target until the word returns.
                        pcEn       = 1'b0;
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                        saved_we   = 1'b1;
                        state_next = ST_REDIR;
                    end else if (loadUseHazard) begin
                        // Any word returned now is dropped and refetched.
                        pcEn       = 1'b0;
                        ifIdEn     = 1'b0;
                        idExBubble = 1'b1;
                    end else if (instructionMemoryDone) begin
                        state_next = ST_RUN;
                    end else begin
                        pcEn      = 1'b0;
                        ifIdFlush = 1'b1;
                    end
                end
                ST_REDIR: begin
                    ifIdFlush = 1'b1;
                    if (instructionMemoryDone) begin
                        // A branch resolving in this same cycle is the youngest.
                        redirectValid = 1'b1;
                        redirectPC    = branchTaken ? branchTarget : saved_target;
                        idExBubble    = branchTaken;
                        take_redirect = 1'b1;
                    end else begin
                        pcEn       = 1'b0;
                        idExBubble = branchTaken;
                        saved_we   = branchTaken;
                    end
                end
                ST_FLUSH: begin
                    ifIdFlush = 1'b1;
                    if (branchTaken) begin
                        redirectValid = 1'b1;
                        redirectPC    = branchTarget;
                        idExBubble    = 1'b1;
                        take_redirect = 1'b1;
                    end else if (flush_cnt <= 3'd1) begin
                        flush_cnt_next = 3'd0;
                        state_next     = ST_RUN;
                    end else begin
                        flush_cnt_next = flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase

            if (take_redirect) begin
                state_next     = (FLUSH_EFF > 1) ? ST_FLUSH : ST_RUN;
                flush_cnt_next = FLUSH_LOAD;
            end

            // HALT retiring overrides every other transition.
            if (haltRetire) begin
                state_next = ST_HALT;
            end
        end

        if (rst) begin
            pcEn          = 1'b0;
            ifIdEn        = 1'b1;
            ifIdFlush     = 1'b1;
            idExBubble    = 1'b1;
            backEn        = 1'b0;
            halted        = 1'b0;
            redirectValid = 1'b0;
            redirectPC    = 16'h0000;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (FLUSH_CYCLES=3, narrow counter).
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ims, imd, dms, lu, bt, hr;
    logic [15:0]      tgt;
    logic             pcEn, ifIdEn, ifIdFlush, idExBubble, backEn;
    logic             redirectValid, halted;
    logic [15:0]      redirectPC;
    logic [CNT_W-1:0] stallCount;

    int errors = 0;
    int checks = 0;

    pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .instructionMemoryStall (ims),
        .instructionMemoryDone  (imd),
        .dataMemoryStall        (dms),
        .loadUseHazard          (lu),
        .branchTaken            (bt),
        .branchTarget           (tgt),
        .haltRetire             (hr),
        .pcEn                   (pcEn),
        .ifIdEn                 (ifIdEn),
        .ifIdFlush              (ifIdFlush),
        .idExBubble             (idExBubble),
        .backEn                 (backEn),
        .redirectValid          (redirectValid),
        .redirectPC             (redirectPC),
        .halted                 (halted),
        .stallCount             (stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for the next cycle, then move to the mid-cycle sample point.
    task automatic drive(input logic s, input logic d, input logic m, input logic l,
                         input logic b, input logic [15:0] t, input logic h);
        ims = s; imd = d; dms = m; lu = l; bt = b; tgt = t; hr = h;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 16'h0000, 0);
    endtask

    initial begin
        rst = 1'b1;
        ims = 0; imd = 0; dms = 0; lu = 0; bt = 0; tgt = 16'h0; hr = 0;
        @(negedge clk);
        chk("rst_pcEn",   pcEn, 0);
        chk("rst_flush",  ifIdFlush, 1);
        chk("rst_bubble", idExBubble, 1);
        chk("rst_backEn", backEn, 0);
        chk("rst_ifIdEn", ifIdEn, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle after reset
        idle();
        chk("idle_pcEn",   pcEn, 1);
        chk("idle_ifIdEn", ifIdEn, 1);
        chk("idle_backEn", backEn, 1);
        chk("idle_halted", halted, 0);
        chk("idle_cnt",    stallCount, 0);
        next_cycle();

        // Fetch stall for 3 cycles then done
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 16'h0000, 0);
            chk("ims_pcEn",  pcEn, 0);
            chk("ims_flush", ifIdFlush, 1);
            next_cycle();
        end
        drive(0, 1, 0, 0, 0, 16'h0000, 0);
        chk("done_pcEn",  pcEn, 1);
        chk("done_flush", ifIdFlush, 0);
        next_cycle();
        idle();
        chk("ims_cnt", stallCount, 3);
        next_cycle();

        // Branch while fetch outstanding, done two cycles later
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 16'h0040, 0);
        chk("iw_br_pcEn",  pcEn, 0);
        chk("iw_br_rv",    redirectValid, 0);
        chk("iw_br_bub",   idExBubble, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 16'h1234, 0);
        chk("redir_pcEn",  pcEn, 0);
        chk("redir_rv",    redirectValid, 0);
        chk("redir_flush", ifIdFlush, 1);
        next_cycle();
        drive(0, 1, 0, 0, 0, 16'h1234, 0);
        chk("redir_done_pcEn", pcEn, 1);
        chk("redir_done_rv",   redirectValid, 1);
        chk("redir_done_pc",   redirectPC, 16'h0040);
        next_cycle();
        idle();
        chk("post_redir_rv",    redirectValid, 0);
        chk("post_redir_flush", ifIdFlush, 1);
        next_cycle();
        idle();
        chk("post_redir_flush2", ifIdFlush, 1);
        next_cycle();
        idle();
        chk("post_redir_run", ifIdFlush, 0);
        chk("redir_cnt", stallCount, 6);
        next_cycle();

        // Branch from RUN with three flush cycles
        drive(0, 0, 0, 0, 1, 16'h0100, 0);
        chk("br_rv",    redirectValid, 1);
        chk("br_pc",    redirectPC, 16'h0100);
        chk("br_flush", ifIdFlush, 1);
        chk("br_bub",   idExBubble, 1);
        chk("br_pcEn",  pcEn, 1);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("fl_flush", ifIdFlush, 1);
            chk("fl_bub",   idExBubble, 0);
            next_cycle();
        end
        idle();
        chk("fl_end_flush", ifIdFlush, 0);
        chk("fl_cnt", stallCount, 6);
        next_cycle();

        // Data-memory stall overrides load-use and branch
        drive(0, 0, 1, 1, 1, 16'h0200, 0);
        chk("dms_pcEn",   pcEn, 0);
        chk("dms_ifIdEn", ifIdEn, 0);
        chk("dms_backEn", backEn, 0);
        chk("dms_rv",     redirectValid, 0);
        chk("dms_flush",  ifIdFlush, 0);
        chk("dms_bub",    idExBubble, 0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 16'h0200, 0);
        chk("dms_after_rv",   redirectValid, 1);
        chk("dms_after_pc",   redirectPC, 16'h0200);
        chk("dms_after_pcEn", pcEn, 1);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            next_cycle();
        end

        // Load-use hazard held long enough to saturate the counter
        drive(0, 0, 0, 1, 0, 16'h0000, 0);
        chk("lu_pcEn",   pcEn, 0);
        chk("lu_ifIdEn", ifIdEn, 0);
        chk("lu_bub",    idExBubble, 1);
        chk("lu_cnt",    stallCount, 7);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 0, 16'h0000, 0);
            next_cycle();
        end
        idle();
        chk("sat_cnt", stallCount, 15);
        next_cycle();

        // HALT retiring while in IWAIT
        drive(1, 0, 0, 0, 0, 16'h0000, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 16'h0000, 1);
        chk("iw_halt_pcEn", pcEn, 0);
        chk("iw_halt_h",    halted, 0);
        next_cycle();
        drive(0, 0, 1, 0, 1, 16'h0300, 0);
        chk("halt_h",      halted, 1);
        chk("halt_pcEn",   pcEn, 0);
        chk("halt_backEn", backEn, 0);
        chk("halt_rv",     redirectValid, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 1, 16'h0300, 0);
            next_cycle();
        end
        idle();
        chk("halt_persist", halted, 1);
        rst = 1'b1;
        #1;
        chk("halt_rst_h", halted, 0);
        next_cycle();
        rst = 1'b0;
        idle();
        chk("after_rst_h",    halted, 0);
        chk("after_rst_pcEn", pcEn, 1);
        chk("after_rst_cnt",  stallCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
